// File: rtl/utpu_pkg.sv
// utpu_pkg: shared types, field offsets and sizing for the uTPU instruction sequencer
package utpu_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int ADDRESS_SIZE = 9;
  localparam int OPCODE_WIDTH = 3;
  localparam int ARRAY_SIZE = 2;
  localparam int COMPUTE_CYCLES = 2 * ARRAY_SIZE - 1;
  localparam int CC_W = $clog2(COMPUTE_CYCLES);
  localparam logic [CC_W-1:0] CC_LAST = CC_W'(COMPUTE_CYCLES - 1);
  localparam int OP_LSB = 0;
  localparam int N_LSB = 3;
  localparam int N_W = 4;
  localparam int F_BIT = 7;
  localparam int A_LSB = 8;
  typedef enum logic [2:0] {
    OP_STORE, OP_FETCH, OP_RUN, OP_LOAD, OP_HALT, OP_NOP, OP_ILL6, OP_ILL7
  } opcode_e;
  typedef enum logic [1:0] {BOP_WR_RX, BOP_RD_TX, BOP_RD_PE, BOP_WR_PE} buf_op_e;
  typedef enum logic [3:0] {
    IDLE, GET_LO, GET_HI, DECODE, ST_POP, ST_WR, FT_RD, LD_RD, RUN_CALC, RUN_WR, HALT
  } state_e;
  function automatic state_e dispatch(opcode_e op);
    return op == OP_STORE ? ST_POP :
           op == OP_FETCH ? FT_RD :
           op == OP_RUN   ? RUN_CALC :
           op == OP_LOAD  ? LD_RD :
           op == OP_HALT  ? HALT : GET_LO;
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: RX/TX FIFO, unified buffer and PE array control bundle
interface instr_sequencer_if;
  import utpu_pkg::*;
  logic rx_empty;
  logic [FIFO_DATA_WIDTH-1:0] rx_data;
  logic rx_re;
  logic tx_full;
  logic buf_req;
  buf_op_e buf_op;
  logic [ADDRESS_SIZE-1:0] buf_addr;
  logic [FIFO_DATA_WIDTH-1:0] buf_wdata;
  logic buf_done;
  logic pe_load_en;
  logic pe_compute;
  logic quant_en;
  logic relu_en;
  modport master (
    input rx_empty, rx_data, tx_full, buf_done,
    output rx_re, buf_req, buf_op, buf_addr, buf_wdata, pe_load_en, pe_compute, quant_en, relu_en
  );
  modport slave (
    output rx_empty, rx_data, tx_full, buf_done,
    input rx_re, buf_req, buf_op, buf_addr, buf_wdata, pe_load_en, pe_compute, quant_en, relu_en
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 16-bit instructions from the RX FIFO and sequences buffer/PE transactions
module instr_sequencer
  import utpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  instr_sequencer_if.master bus,
  output logic busy,
  output logic halted,
  output logic illegal_op
);
  state_e state, state_nx;
  logic [15:0] ir;
  logic [ADDRESS_SIZE-1:0] addr;
  logic [N_W-1:0] cnt;
  logic [FIFO_DATA_WIDTH-1:0] wdata;
  logic [CC_W-1:0] ccnt;
  logic held, q, r, ill, pop, req, done, last;
  opcode_e op;
  assign op = opcode_e'(ir[OP_LSB +: OPCODE_WIDTH]);
  assign last = cnt == '0;
  assign pop = state inside {GET_LO, GET_HI, ST_POP} && !bus.rx_empty;
  // a FETCH request, once raised, stays up even if tx_full reasserts
  assign req = state inside {ST_WR, LD_RD, RUN_WR} || (state == FT_RD && (held || !bus.tx_full));
  assign done = req && bus.buf_done;
  assign bus.rx_re = pop;
  assign bus.buf_req = req;
  assign bus.buf_op = state == FT_RD ? BOP_RD_TX : state == LD_RD ? BOP_RD_PE :
                      state == RUN_WR ? BOP_WR_PE : BOP_WR_RX;
  assign bus.buf_addr = addr;
  assign bus.buf_wdata = wdata;
  assign bus.pe_load_en = state == LD_RD;
  assign bus.pe_compute = state == RUN_CALC;
  assign bus.quant_en = q;
  assign bus.relu_en = r;
  assign busy = !(state inside {IDLE, HALT});
  assign halted = state == HALT;
  assign illegal_op = ill;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT: state_nx = start ? GET_LO : state;
      GET_LO:     state_nx = bus.rx_empty ? GET_LO : GET_HI;
      GET_HI:     state_nx = bus.rx_empty ? GET_HI : DECODE;
      DECODE:     state_nx = dispatch(op);
      ST_POP:     state_nx = bus.rx_empty ? ST_POP : ST_WR;
      ST_WR, FT_RD, LD_RD:
        state_nx = !done ? state : last ? GET_LO : state == ST_WR ? ST_POP : state;
      RUN_CALC:   state_nx = ccnt == CC_LAST ? RUN_WR : RUN_CALC;
      RUN_WR:     state_nx = done ? GET_LO : RUN_WR;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ir <= '0;
      addr <= '0;
      cnt <= '0;
      wdata <= '0;
      ccnt <= '0;
      held <= 1'b0;
      q <= 1'b0;
      r <= 1'b0;
      ill <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop && state == GET_LO) ir[7:0] <= bus.rx_data;
      if (pop && state == GET_HI) ir[15:8] <= bus.rx_data;
      if (pop && state == ST_POP) wdata <= bus.rx_data;
      if (state == DECODE) begin
        // RUN reuses F as quant_en, so its address high bit is forced to 0
        addr <= {op != OP_RUN && ir[F_BIT], ir[A_LSB +: 8]};
        cnt <= ir[N_LSB +: N_W];
        if (op == OP_RUN) begin
          q <= ir[F_BIT];
          r <= ir[N_LSB];
        end
        if (op == OP_ILL6 || op == OP_ILL7) ill <= 1'b1;
      end
      if (done) begin
        addr <= addr + 1'b1;
        cnt <= cnt - 1'b1;
      end
      held <= state == FT_RD && req && !done;
      ccnt <= state == RUN_CALC ? ccnt + 1'b1 : '0;
    end
  end
endmodule
